mem_arbiter: RTL

Two-requester arbiter that shares the single main-memory port (DMemory line interface) between the instruction-cache and data-cache FSMs. It sits between both cache controllers and DMemory. It grants one line transaction at a time, latches the winner's request, holds it on the memory port until memory answers, and routes the 128-bit response back to the owner. It also detects a memory port that never answers.

---
 rtl/mem_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one DMemory line port between I-cache and D-cache; MEM_ARB_FIXED_PRIO_EN selects fixed D-cache priority
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_rsp_ready,
  output logic [LINE_W-1:0] ic_rsp_data,
  input  logic              dc_req_valid,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_req_data,
  output logic              dc_rsp_ready,
  output logic [LINE_W-1:0] dc_rsp_data,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_rsp_ready,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              busy,
  output logic              owner,
  output logic              err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GRANT_IC, GRANT_DC, RESP} state_t;
  state_t            state, state_nx;
  logic              owner_q, req_rw, err_q, any_req, pick_dc, granted, grant_now;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_data, rsp_data;
  logic [CW-1:0]     cnt, cnt_inc;
  assign any_req   = ic_req_valid | dc_req_valid;
  assign granted   = (state == GRANT_IC) | (state == GRANT_DC);
  assign grant_now = (state == IDLE) & any_req;
  assign cnt_inc   = (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick_dc = dc_req_valid;
`else
  logic last_owner;
  assign pick_dc = dc_req_valid & (~ic_req_valid | ~last_owner);
  // Round-robin pointer: remembers who won the most recent grant
  always_ff @(posedge clock)
    if (!reset) last_owner <= 1'b1;
    else if (grant_now) last_owner <= pick_dc;
`endif
  // Next-state logic: one line transaction at a time, response pulse then back to idle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:               state_nx = any_req ? (pick_dc ? GRANT_DC : GRANT_IC) : IDLE;
      GRANT_IC, GRANT_DC: state_nx = mem_rsp_ready ? RESP : state;
      default:            state_nx = IDLE;
    endcase
  end
  // State, latched request/response and the saturating wait counter with sticky timeout flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      owner_q  <= 1'b0;
      req_rw   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      rsp_data <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_now) begin
        owner_q  <= pick_dc;
        req_rw   <= pick_dc & dc_req_rw;
        req_addr <= pick_dc ? dc_req_addr : ic_req_addr;
        req_data <= pick_dc ? dc_req_data : '0;
        cnt      <= '0;
      end
      if (granted && mem_rsp_ready) rsp_data <= req_rw ? '0 : mem_rsp_data;
      if (granted && !mem_rsp_ready) begin
        cnt <= cnt_inc;
        if (cnt_inc == CW'(TIMEOUT)) err_q <= 1'b1;
      end
    end
  end
  assign mem_req_valid = granted;
  assign mem_req_rw    = req_rw;
  assign mem_req_addr  = req_addr;
  assign mem_req_data  = req_data;
  assign busy          = state != IDLE;
  assign owner         = owner_q;
  assign err_timeout   = err_q;
  assign ic_rsp_ready  = (state == RESP) & ~owner_q;
  assign dc_rsp_ready  = (state == RESP) & owner_q;
  assign ic_rsp_data   = ic_rsp_ready ? rsp_data : '0;
  assign dc_rsp_data   = dc_rsp_ready ? rsp_data : '0;
endmodule
